data_memory_responder: RTL
==========================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the processor's data-memory request interface: accepts read/write
//  strobes with a 7-bit line number, performs the access on an internal 8-bit RAM after
//  programmable wait states, and returns data plus a one-cycle ack/err.
//  Sits between the multi-cycle control FSM and the data RAM, replacing fixed-timing
//  strobes with a proper request/acknowledge handshake.
// PARAMETERS
//  ADDR_W       7    line-number width
//  DATA_W       8    data width
//  DEPTH        128  implemented lines; valid addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_W)
//  WAIT_STATES  1    idle cycles inserted between acceptance and access (0..15)
// PORTS
//  clk       in   1       single clock, all state changes on posedge
//  rst       in   1       synchronous, active-high reset
//  rd_req    in   1       read request (level)
//  wr_req    in   1       write request (level)
//  addr      in   ADDR_W  line number, sampled at acceptance
//  wdata     in   DATA_W  write data, sampled at acceptance
//  copy_req  in   1       memory-to-memory copy request (level)
//  copy_src  in   ADDR_W  copy source line
//  copy_dst  in   ADDR_W  copy destination line
//  rdata     out  DATA_W  read data, valid from ack edge until next read ack
//  ack       out  1       one-cycle pulse: operation complete
//  err       out  1       one-cycle pulse: request rejected, RAM untouched
//  busy      out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rdata=0, ack=0, err=0, busy=0, wait counter=0; RAM contents unchanged.
//  - Reset mid-operation aborts immediately; a write not yet at its ACCESS edge never happens.
//  - FSM: IDLE -> WAIT -> ACCESS -> DONE -> IDLE; copy: IDLE -> WAIT -> CP_RD -> CP_WR -> DONE.
//  - IDLE: samples requests every edge; on acceptance latches addr/wdata (or src/dst) and
//    enters WAIT (or ACCESS/CP_RD directly when WAIT_STATES=0).
//  - WAIT: counts exactly WAIT_STATES cycles.
//  - ACCESS: read -> rdata<=RAM[addr]; write -> RAM[addr]<=wdata; ack<=1 same edge.
//  - Latency: request accepted on edge N -> ack high after edge N+WAIT_STATES+1, one cycle.
//  - DONE: ack or err high; requests ignored. Requester must drop req by the end of the
//    DONE cycle, else it is accepted again as a new request.
//  - Reject (err pulse, no RAM access, straight to DONE after one cycle):
//    more than one of rd_req/wr_req/copy_req high; addr (or src/dst) >= DEPTH.
//  - Read-after-write to same line returns new data (write finished before ack).
//  - rdata only updates on read/copy ack; writes and errors leave it unchanged.
// CONFIGURATION
//  DMEM_RESP_COPY_EN defined: copy_req performs CP_RD (tmp<=RAM[src]) then
//    CP_WR (RAM[dst]<=tmp, rdata<=tmp, ack<=1); latency WAIT_STATES+2. src==dst legal, no-op value.
//  Undefined: copy ports remain, copy_req alone -> err pulse; copy logic not built.
// TESTING
//  - rst held 2 cycles mid-write to line 5 -> outputs all 0, state IDLE, RAM[5] unchanged.
//  - wr_req addr=7 wdata=8'hA5, then rd_req addr=7 -> ack after WAIT_STATES+1 cycles, rdata=8'hA5.
//  - WAIT_STATES=0 and 3: measure accept-to-ack distance = 1 and 4 cycles; busy high throughout.
//  - rd_req and wr_req together, addr=3 -> err one cycle, ack=0, RAM[3] and rdata unchanged.
//  - req held high through DONE -> second ack exactly WAIT_STATES+2 cycles after first.
//  - COPY_EN: RAM[10]=8'h3C, copy src=10 dst=127 -> ack, RAM[127]=8'h3C, rdata=8'h3C;
//    without COPY_EN same stimulus -> err, RAM[127] unchanged.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: request/acknowledge front end for the processor's data RAM.
// Latency: accept edge N -> ack after edge N+WAIT_STATES+1 (copy N+WAIT_STATES+2); err after edge N.
// Backpressure: busy outside IDLE; requests are sampled in IDLE and on the closing edge of DONE.
// Optional feature: define DMEM_RESP_COPY_EN to build the memory-to-memory copy path.
module data_memory_responder #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              copy_req,
    input  logic [ADDR_W-1:0] copy_src,
    input  logic [ADDR_W-1:0] copy_dst,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_CP_RD,
        S_CP_WR,
        S_DONE
    } state_t;

    // One past the last implemented line, widened so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L   = DEPTH[ADDR_W:0];
    // Counter value on the final wait cycle; unused when WAIT_STATES is 0.
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t            state;
    state_t            nextState;
    state_t            firstState;
    logic [3:0]        waitCnt;

    logic [DATA_W-1:0] mem [DEPTH];

    // Request captured at acceptance.
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              opWrite;

    // Request decode.
    logic [1:0]        reqCount;
    logic              anyReq;
    logic              multiReq;
    logic              addrBad;
    logic              copyBad;
    logic              reqBad;

    // FSM outputs.
    logic              acceptReq;
    logic              ackNext;
    logic              errNext;
    logic              memWe;
    logic [ADDR_W-1:0] memWaddr;
    logic [DATA_W-1:0] memWdata;
    logic              rdataLoad;
    logic [DATA_W-1:0] rdataNext;

`ifdef DMEM_RESP_COPY_EN
    logic              opCopy;
    logic [ADDR_W-1:0] srcQ;
    logic [ADDR_W-1:0] dstQ;
    logic [DATA_W-1:0] tmpQ;
    logic              tmpLoad;
    logic              srcBad;
    logic              dstBad;

    assign srcBad  = ({1'b0, copy_src} >= DEPTH_L);
    assign dstBad  = ({1'b0, copy_dst} >= DEPTH_L);
    assign copyBad = copy_req && (srcBad || dstBad);
`else
    // Copy ports stay on the boundary but a copy request is always refused.
    logic              unusedCopyPorts;

    assign unusedCopyPorts = ^{copy_src, copy_dst};
    assign copyBad         = copy_req;
`endif

    assign reqCount = {1'b0, rd_req} + {1'b0, wr_req} + {1'b0, copy_req};
    assign anyReq   = rd_req || wr_req || copy_req;
    assign multiReq = (reqCount > 2'd1);
    assign addrBad  = (rd_req || wr_req) && ({1'b0, addr} >= DEPTH_L);
    assign reqBad   = multiReq || addrBad || copyBad;
    assign busy     = (state != S_IDLE);

    // Where an accepted request goes first: straight to its access when there are no wait states.
    always_comb begin
        firstState = S_WAIT;
        if (WAIT_STATES == 0) begin
`ifdef DMEM_RESP_COPY_EN
            firstState = copy_req ? S_CP_RD : S_ACCESS;
`else
            firstState = S_ACCESS;
`endif
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        nextState = state;
        acceptReq = 1'b0;
        ackNext   = 1'b0;
        errNext   = 1'b0;
        memWe     = 1'b0;
        memWaddr  = addrQ;
        memWdata  = wdataQ;
        rdataLoad = 1'b0;
        rdataNext = rdata;
`ifdef DMEM_RESP_COPY_EN
        tmpLoad   = 1'b0;
`endif
        case (state)
            // DONE's closing edge samples requests like IDLE, so a held request
            // is served again without an extra idle cycle.
            S_IDLE, S_DONE: begin
                nextState = S_IDLE;
                if (anyReq) begin
                    if (reqBad) begin
                        errNext   = 1'b1;
                        nextState = S_DONE;
                    end else begin
                        acceptReq = 1'b1;
                        nextState = firstState;
                    end
                end
            end
            S_WAIT: begin
                if (waitCnt == WAIT_LAST) begin
`ifdef DMEM_RESP_COPY_EN
                    nextState = opCopy ? S_CP_RD : S_ACCESS;
`else
                    nextState = S_ACCESS;
`endif
                end
            end
            S_ACCESS: begin
                ackNext   = 1'b1;
                nextState = S_DONE;
                if (opWrite) begin
                    memWe = 1'b1;
                end else begin
                    rdataLoad = 1'b1;
                    rdataNext = mem[addrQ];
                end
            end
`ifdef DMEM_RESP_COPY_EN
            S_CP_RD: begin
                tmpLoad   = 1'b1;
                nextState = S_CP_WR;
            end
            S_CP_WR: begin
                memWe     = 1'b1;
                memWaddr  = dstQ;
                memWdata  = tmpQ;
                rdataLoad = 1'b1;
                rdataNext = tmpQ;
                ackNext   = 1'b1;
                nextState = S_DONE;
            end
`endif
            default: nextState = S_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Response pulses, read-data holding register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            waitCnt <= '0;
        end else begin
            ack <= ackNext;
            err <= errNext;
            if (rdataLoad) begin
                rdata <= rdataNext;
            end
            if (state == S_WAIT) begin
                waitCnt <= waitCnt + 4'd1;
            end else begin
                waitCnt <= '0;
            end
        end
    end

    // Capture the request operands on acceptance; they are only meaningful while busy.
    always_ff @(posedge clk) begin
        if (acceptReq) begin
            addrQ   <= addr;
            wdataQ  <= wdata;
            opWrite <= wr_req;
`ifdef DMEM_RESP_COPY_EN
            opCopy  <= copy_req;
            srcQ    <= copy_src;
            dstQ    <= copy_dst;
`endif
        end
    end

`ifdef DMEM_RESP_COPY_EN
    // Copy staging register: holds the source line between the two copy steps.
    always_ff @(posedge clk) begin
        if (tmpLoad) begin
            tmpQ <= mem[srcQ];
        end
    end
`endif

    // RAM write port; never written while reset is asserted and never cleared by reset.
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem[memWaddr] <= memWdata;
        end
    end

endmodule
